// File: rtl/mul_shift_unit_if.sv
// rtl/mul_shift_unit_if.sv - operand request / write-back bundle for the multiply-shift unit
interface mul_shift_unit_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              START;
    logic [2:0]        OP;
    logic [WIDTH-1:0]  DATA1;
    logic [WIDTH-1:0]  DATA2;
    logic [ADDR_W-1:0] DEST;
    logic              BUSY;
    logic [WIDTH-1:0]  WB_DATA;
    logic [WIDTH-1:0]  WB_HI;
    logic [ADDR_W-1:0] WB_ADDR;
    logic              WB_WRITE;
    logic              ERR;

    // control unit / register file side
    modport master (
        output START, OP, DATA1, DATA2, DEST,
        input  BUSY, WB_DATA, WB_HI, WB_ADDR, WB_WRITE, ERR
    );

    // execution unit side
    modport slave (
        input  START, OP, DATA1, DATA2, DEST,
        output BUSY, WB_DATA, WB_HI, WB_ADDR, WB_WRITE, ERR
    );
endinterface

// File: rtl/mul_shift_unit.sv
// rtl/mul_shift_unit.sv - iterative unsigned multiply and shift/rotate unit, one bit-step per clock
module mul_shift_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input logic            CLK,
    input logic            RESET,
    mul_shift_unit_if.slave bus
);
    localparam int LW    = $clog2(WIDTH);
    localparam int CNT_W = LW + 1;

    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] AMT_FULL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mcand;
    logic [ADDR_W-1:0]  dest_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   n_load;
    logic               op_reserved;
    logic               in_reserved;

    logic [WIDTH-1:0]   wb_data_q;
    logic [WIDTH-1:0]   wb_hi_q;
    logic [ADDR_W-1:0]  wb_addr_q;
    logic               wb_write;
    logic               err;

    assign op_reserved  = (op_q > OP_ROR);
    assign in_reserved  = (bus.OP > OP_ROR);

    assign bus.BUSY     = (state != IDLE);
    assign bus.WB_DATA  = wb_data_q;
    assign bus.WB_HI    = wb_hi_q;
    assign bus.WB_ADDR  = wb_addr_q;
    assign bus.WB_WRITE = wb_write;
    assign bus.ERR      = err;

    // Step count for the incoming request; shifts saturate at WIDTH, rotates wrap.
    always_comb begin
        n_load = '0;
        case (bus.OP)
            OP_MUL:                 n_load = CNT_FULL;
            OP_SLL, OP_SRL, OP_SRA: n_load = (bus.DATA2 >= AMT_FULL) ? CNT_FULL
                                                                     : bus.DATA2[CNT_W-1:0];
            OP_ROR:                 n_load = {1'b0, bus.DATA2[LW-1:0]};
            default:                n_load = '0;
        endcase
    end

    // One iteration of the captured operation; shifts live in the low half with the high half zero.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_step = acc;
        case (op_q)
            OP_MUL:  acc_step = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
            OP_SLL:  acc_step = {{WIDTH{1'b0}}, acc[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_step = {{WIDTH{1'b0}}, 1'b0, acc[WIDTH-1:1]};
            OP_SRA:  acc_step = {{WIDTH{1'b0}}, acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROR:  acc_step = {{WIDTH{1'b0}}, acc[0], acc[WIDTH-1:1]};
            default: acc_step = acc;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and the one-cycle completion strobes, which are only ever raised in DONE.
    always_comb begin
        state_next = state;
        wb_write   = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) state_next = (n_load == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == CNT_ONE) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                if (op_reserved) err      = 1'b1;
                else             wb_write = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers; results load only on the way into DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q      <= '0;
            mcand     <= '0;
            dest_q    <= '0;
            cnt       <= '0;
            acc       <= '0;
            wb_data_q <= '0;
            wb_hi_q   <= '0;
            wb_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        op_q   <= bus.OP;
                        mcand  <= bus.DATA1;
                        dest_q <= bus.DEST;
                        cnt    <= n_load;
                        acc    <= (bus.OP == OP_MUL) ? {{WIDTH{1'b0}}, bus.DATA2}
                                                     : {{WIDTH{1'b0}}, bus.DATA1};
                        if (n_load == '0) begin
                            wb_data_q <= in_reserved ? '0 : bus.DATA1;
                            wb_hi_q   <= '0;
                            wb_addr_q <= bus.DEST;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        wb_data_q <= acc_step[WIDTH-1:0];
                        wb_hi_q   <= (op_q == OP_MUL) ? acc_step[2*WIDTH-1:WIDTH] : '0;
                        wb_addr_q <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_shift_unit.sv
// tb/tb_mul_shift_unit.sv - directed vector bench for mul_shift_unit
module tb_mul_shift_unit;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    mul_shift_unit_if #(.WIDTH(8), .ADDR_W(3)) bus ();

    mul_shift_unit #(.WIDTH(8), .ADDR_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] dest;
        int         n;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       err;
    } vec_t;

    vec_t vecs[13];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int busy_cnt = 0;
        int wr_cnt = 0;
        int err_cnt = 0;
        int strobe_cyc = -1;
        logic [7:0] s_lo = '0;
        logic [7:0] s_hi = '0;
        logic [2:0] s_addr = '0;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP    = v.op;
        bus.DATA1 = v.d1;
        bus.DATA2 = v.d2;
        bus.DEST  = v.dest;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.OP    = ~v.op;
        bus.DATA1 = ~v.d1;
        bus.DATA2 = v.d2 + 8'd3;
        bus.DEST  = ~v.dest;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (bus.BUSY) busy_cnt++;
            if (bus.WB_WRITE) wr_cnt++;
            if (bus.ERR) err_cnt++;
            if (bus.WB_WRITE || bus.ERR) begin
                strobe_cyc = i;
                s_lo   = bus.WB_DATA;
                s_hi   = bus.WB_HI;
                s_addr = bus.WB_ADDR;
            end
            if (!bus.BUSY) break;
        end
        chk({tag, " busy_cycles"}, busy_cnt, v.n + 1);
        chk({tag, " strobe_cycle"}, strobe_cyc, v.n + 1);
        chk({tag, " write_count"}, wr_cnt, v.err ? 0 : 1);
        chk({tag, " err_count"}, err_cnt, v.err ? 1 : 0);
        chk({tag, " wb_data"}, s_lo, v.lo);
        chk({tag, " wb_hi"}, s_hi, v.hi);
        chk({tag, " wb_addr"}, s_addr, v.dest);
        @(negedge CLK);
        chk({tag, " hold_data"}, bus.WB_DATA, v.lo);
        chk({tag, " hold_hi"}, bus.WB_HI, v.hi);
        chk({tag, " idle_strobes"}, {bus.WB_WRITE, bus.ERR, bus.BUSY}, 3'b000);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, bus.BUSY, 1'b0);
        chk({tag, " wb_data"}, bus.WB_DATA, 8'h00);
        chk({tag, " wb_hi"}, bus.WB_HI, 8'h00);
        chk({tag, " wb_addr"}, bus.WB_ADDR, 3'd0);
        chk({tag, " strobes"}, {bus.WB_WRITE, bus.ERR}, 2'b00);
    endtask

    initial begin
        int falls;
        int writes;
        int wr_cyc;
        logic prev_busy;
        logic [7:0] wr_lo;
        logic [2:0] wr_addr;
        vec_t v3;

        //        op      d1     d2     dest  n  lo     hi     err
        vecs[0]  = '{3'b000, 8'h0D, 8'h0B, 3'd5, 8, 8'h8F, 8'h00, 1'b0};
        vecs[1]  = '{3'b000, 8'hFF, 8'hFF, 3'd2, 8, 8'h01, 8'hFE, 1'b0};
        vecs[2]  = '{3'b000, 8'h00, 8'hA5, 3'd3, 8, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{3'b011, 8'h90, 8'd3,  3'd1, 3, 8'hF2, 8'h00, 1'b0};
        vecs[4]  = '{3'b001, 8'h81, 8'd9,  3'd4, 8, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{3'b100, 8'h81, 8'd9,  3'd6, 1, 8'hC0, 8'h00, 1'b0};
        vecs[6]  = '{3'b010, 8'h5A, 8'd0,  3'd7, 0, 8'h5A, 8'h00, 1'b0};
        vecs[7]  = '{3'b110, 8'h77, 8'd2,  3'd3, 0, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{3'b010, 8'hF0, 8'd4,  3'd2, 4, 8'h0F, 8'h00, 1'b0};
        vecs[9]  = '{3'b011, 8'h80, 8'd200, 3'd5, 8, 8'hFF, 8'h00, 1'b0};
        vecs[10] = '{3'b011, 8'h40, 8'd8,  3'd1, 8, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{3'b100, 8'h12, 8'd12, 3'd6, 4, 8'h21, 8'h00, 1'b0};
        vecs[12] = '{3'b001, 8'h03, 8'd2,  3'd4, 2, 8'h0C, 8'h00, 1'b0};

        bus.START = 1'b0;
        bus.OP    = '0;
        bus.DATA1 = '0;
        bus.DATA2 = '0;
        bus.DEST  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk_zero("reset");

        for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // START during RUN and DONE must be ignored
        falls = 0; writes = 0; wr_cyc = -1; wr_lo = '0; wr_addr = '0;
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = 3'b000; bus.DATA1 = 8'h0D; bus.DATA2 = 8'h0B; bus.DEST = 3'd5;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        prev_busy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK);
            if (prev_busy && !bus.BUSY) falls++;
            prev_busy = bus.BUSY;
            if (bus.WB_WRITE) begin
                writes++; wr_cyc = i; wr_lo = bus.WB_DATA; wr_addr = bus.WB_ADDR;
            end
            if (i == 3 || i == 9) begin
                bus.START = 1'b1; bus.OP = 3'b001; bus.DATA1 = 8'h33; bus.DATA2 = 8'd1; bus.DEST = 3'd7;
            end else begin
                bus.START = 1'b0;
            end
        end
        chk("ignore busy_falls", falls, 1);
        chk("ignore writes", writes, 1);
        chk("ignore write_cycle", wr_cyc, 9);
        chk("ignore wb_data", wr_lo, 8'h8F);
        chk("ignore wb_addr", wr_addr, 3'd5);
        chk("ignore final_busy", bus.BUSY, 1'b0);

        // reset in the middle of a multiply
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = 3'b000; bus.DATA1 = 8'hFF; bus.DATA2 = 8'hFF; bus.DEST = 3'd6;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk_zero("midreset");
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.WB_WRITE || bus.ERR) writes++;
        end
        chk("midreset no_strobe", writes, 0);

        v3 = '{3'b000, 8'h03, 8'h07, 3'd2, 8, 8'h15, 8'h00, 1'b0};
        run_op(v3, "mul3x7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
